// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   - FSM state encoding for uart_rx_ctrl
//   - Frame geometry: one start bit, eight data bits (LSB first), one stop bit
//   - Default bit-cell length in clock cycles (50 MHz clock, 9600 baud)
package uart_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    localparam int FRAME_BITS    = 10;
    localparam int DATA_BITS     = 8;
    localparam int DEF_BIT_TICKS = 5208;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-cell timer for the UART receiver.
// A CNT_W-bit up-counter that is cleared by clr, advances while en is high,
// and flags the last cycle of a half bit cell and of a full bit cell.
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-high reset, counter to 0
//   clr      synchronous clear, takes priority over en
//   en       count enable
//   half_tc  counter equals BIT_TICKS/2 - 1
//   full_tc  counter equals BIT_TICKS - 1
module uart_bit_timer #(
    parameter int BIT_TICKS = 5208,
    parameter int CNT_W     = 13
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic half_tc,
    output logic full_tc
);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_TICKS / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BIT_TICKS - 1);

    logic [CNT_W-1:0] cnt_reg;

    // The controller clears the counter on every terminal count, so it
    // never runs past FULL_LAST and needs no wrap handling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign half_tc = (cnt_reg == HALF_LAST);
    assign full_tc = (cnt_reg == FULL_LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller.
// Oversamples the serial line, finds start bits, times each bit cell and
// drives an external 10-bit shift register (one shift per bit, start bit
// first, stop bit last). After the stop bit it checks framing and hands the
// byte to the host with a one-cycle strobe.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset (also resets the shift register)
//   rx         raw asynchronous serial line, idles high
//   sr         parallel contents of the shift register
//   sh         shift enable, one clock per received bit
//   sdi        serial data into the shift register, valid with sh
//   rx_data    last correctly framed byte
//   rx_valid   one-cycle pulse when rx_data is updated
//   frame_err  one-cycle pulse when the stop bit is 0
//   busy       high from start detection until the frame check is done
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int BIT_TICKS = DEF_BIT_TICKS,
    parameter int CNT_W     = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic [FRAME_BITS-1:0] sr,
    output logic                 sh,
    output logic                 sdi,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    logic [2:0] state_reg;
    logic [3:0] bit_cnt_reg;
    logic       rx_meta_reg;
    logic       rx_s_reg;

    logic tmr_clr;
    logic tmr_en;
    logic half_tc;
    logic full_tc;

    // The start bit lands in sr[0]; only the stop bit is checked for framing.
    logic unused_start_bit;
    assign unused_start_bit = sr[0];

    // The timer runs only while timing a half cell (START) or a full cell
    // (DATA). It is held at zero otherwise, so each phase starts from 0.
    always_comb begin
        tmr_en  = (state_reg == ST_START) || (state_reg == ST_DATA);
        tmr_clr = !tmr_en
               || ((state_reg == ST_START) && half_tc)
               || ((state_reg == ST_DATA)  && full_tc);
    end

    uart_bit_timer #(
        .BIT_TICKS (BIT_TICKS),
        .CNT_W     (CNT_W)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .half_tc (half_tc),
        .full_tc (full_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            sh          <= 1'b0;
            sdi         <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;

            sh        <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (!rx_s_reg) begin
                        state_reg <= ST_START;
                        busy      <= 1'b1;
                    end
                end

                // Re-sample the start bit in the middle of its cell to
                // reject glitches shorter than half a bit.
                ST_START: begin
                    if (half_tc) begin
                        if (!rx_s_reg) begin
                            sh          <= 1'b1;
                            sdi         <= 1'b0;
                            bit_cnt_reg <= 4'd1;
                            state_reg   <= ST_DATA;
                        end else begin
                            busy      <= 1'b0;
                            state_reg <= ST_IDLE;
                        end
                    end
                end

                // Once the stop bit has been shifted (bit_cnt = 10) we spend
                // one more cycle here so that CHECK sees the register after
                // that final shift has taken effect.
                ST_DATA: begin
                    if (bit_cnt_reg == 4'(FRAME_BITS)) begin
                        state_reg <= ST_CHECK;
                    end else if (full_tc) begin
                        sh          <= 1'b1;
                        sdi         <= rx_s_reg;
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                    end
                end

                ST_CHECK: begin
                    busy <= 1'b0;
                    if (sr[FRAME_BITS-1]) begin
                        rx_data   <= sr[DATA_BITS:1];
                        rx_valid  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        frame_err <= 1'b1;
                        state_reg <= ST_BREAK;
                    end
                end

                // A line held low after a bad stop bit must return high
                // before another start bit is accepted.
                ST_BREAK: begin
                    if (rx_s_reg) begin
                        state_reg <= ST_IDLE;
                    end
                end

                default: begin
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
